// File: rtl/tdm_demux_if.sv
// Serial TDM receive bus: the bit stream and its qualifiers in, the published frame and status pulses out.
interface tdm_demux_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 4
);
  logic                   In;
  logic                   InValid;
  logic                   Sync;
  logic [LANES*WIDTH-1:0] Out;
  logic                   OutValid;
  logic                   Err;

  modport master (output In, InValid, Sync, input Out, OutValid, Err);
  modport slave  (input In, InValid, Sync, output Out, OutValid, Err);
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: shifts LANES slots of WIDTH LSB-first bits into a shadow buffer
// and publishes the whole frame at once; Sync misplacement raises a one-cycle Err.
module tdm_demux #(
  parameter int LANES = 4,
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  tdm_demux_if.slave  bus
);
  localparam int N  = LANES * WIDTH;
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   slot_reg, slot_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [N-1:0]    shadow_reg, shadow_next;
  logic [N-1:0]    out_reg, out_next;
  logic            out_valid_reg, out_valid_next;
  logic            err_reg, err_next;

  logic            boundary;
  logic            take;
  logic [SW-1:0]   pos_slot;
  logic [BW-1:0]   pos_bit;
  logic [IW-1:0]   idx;

  assign boundary = (slot_reg == '0) && (bit_reg == '0);
  assign idx      = IW'(int'(pos_slot) * WIDTH + int'(pos_bit));

  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    bit_next       = bit_reg;
    shadow_next    = shadow_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
    err_next       = 1'b0;
    take           = 1'b0;
    pos_slot       = slot_reg;
    pos_bit        = bit_reg;

    if (bus.InValid) begin
      case (state_reg)
        IDLE: begin
          if (bus.Sync) begin
            take       = 1'b1;
            pos_slot   = '0;
            pos_bit    = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (boundary && !bus.Sync) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            take = 1'b1;
            // A Sync anywhere restarts the frame; only off-boundary ones are errors.
            if (bus.Sync) begin
              pos_slot = '0;
              pos_bit  = '0;
              err_next = !boundary;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (take) begin
      shadow_next[idx] = bus.In;
      if (pos_bit == BW'(WIDTH - 1)) begin
        bit_next = '0;
        if (pos_slot == SW'(LANES - 1)) begin
          slot_next      = '0;
          out_next       = shadow_next;
          out_valid_next = 1'b1;
        end else begin
          slot_next = pos_slot + 1'b1;
        end
      end else begin
        slot_next = pos_slot;
        bit_next  = pos_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      slot_reg      <= '0;
      bit_reg       <= '0;
      shadow_reg    <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      bit_reg       <= bit_next;
      shadow_reg    <= shadow_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign bus.Out      = out_reg;
  assign bus.OutValid = out_valid_reg;
  assign bus.Err      = err_reg;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with LANES=4, WIDTH=4: each scenario task checks its own results.
module tb_tdm_demux;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  tdm_demux_if #(.LANES(4), .WIDTH(4)) bus ();

  tdm_demux #(.LANES(4), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and return just after the edge that consumes them.
  task automatic step(input logic d, input logic v, input logic s);
    @(negedge clk);
    bus.In      = d;
    bus.InValid = v;
    bus.Sync    = s;
    @(posedge clk);
    #1;
  endtask

  // Send one frame LSB-first (Sync on the first beat), optionally with InValid=0 gap
  // cycles inserted before beat gap_at; reports when OutValid/Err were seen.
  task automatic send_frame(input logic [15:0] w, input int gap_at, input int gap_len,
                            output int ov_cycle, output int ov_cnt,
                            output int err_cycle, output int err_cnt,
                            output logic [15:0] out_first);
    int b;
    int gaps;
    ov_cycle = 0; ov_cnt = 0; err_cycle = 0; err_cnt = 0; out_first = '0;
    b = 0;
    gaps = 0;
    for (int c = 1; c <= 16 + gap_len; c++) begin
      if (b == gap_at && gaps < gap_len) begin
        step(1'b1, 1'b0, 1'b1);
        gaps++;
      end else begin
        step(w[b], 1'b1, b == 0);
        b++;
      end
      if (bus.OutValid) begin
        ov_cnt++;
        if (ov_cycle == 0) ov_cycle = c;
      end
      if (bus.Err) begin
        err_cnt++;
        if (err_cycle == 0) err_cycle = c;
      end
      if (c == 1) out_first = bus.Out;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.Out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", bus.Out); end
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL reset_ov: got %b want 0", bus.OutValid); end
    total++;
    if (bus.Err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.Err); end
    reset = 1'b0;
    $display("reset: Out=%h OutValid=%b Err=%b", bus.Out, bus.OutValid, bus.Err);
  endtask

  task automatic test_single();
    int ovc, ovn, erc, ern;
    logic [15:0] of;
    send_frame(16'hC35A, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 16 || ovn !== 1) begin bad++; $display("FAIL single_ov: cycle=%0d count=%0d want 16/1", ovc, ovn); end
    total++;
    if (ern !== 0) begin bad++; $display("FAIL single_err: got %0d pulses want 0", ern); end
    total++;
    if (bus.Out !== 16'hC35A) begin bad++; $display("FAIL single_out: got %h want c35a", bus.Out); end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (bus.OutValid !== 1'b0) begin bad++; $display("FAIL single_ov_drop: got %b want 0", bus.OutValid); end
    $display("single: ov_cycle=%0d Out=%h", ovc, bus.Out);
  endtask

  task automatic test_gaps();
    int ovc, ovn, erc, ern;
    logic [15:0] of;
    send_frame(16'hC35A, 5, 3, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 19 || ovn !== 1) begin bad++; $display("FAIL gaps_ov: cycle=%0d count=%0d want 19/1", ovc, ovn); end
    total++;
    if (ern !== 0) begin bad++; $display("FAIL gaps_err: got %0d pulses want 0", ern); end
    total++;
    if (bus.Out !== 16'hC35A) begin bad++; $display("FAIL gaps_out: got %h want c35a", bus.Out); end
    $display("gaps: ov_cycle=%0d Out=%h", ovc, bus.Out);
  endtask

  task automatic test_back_to_back();
    int ovc, ovn, erc, ern;
    logic [15:0] of;
    send_frame(16'hC35A, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 16 || bus.Out !== 16'hC35A) begin bad++; $display("FAIL b2b_first: cycle=%0d Out=%h want 16/c35a", ovc, bus.Out); end
    send_frame(16'h1234, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 16 || ovn !== 1) begin bad++; $display("FAIL b2b_second_ov: cycle=%0d count=%0d want 16/1", ovc, ovn); end
    total++;
    if (ern !== 0) begin bad++; $display("FAIL b2b_err: got %0d pulses want 0", ern); end
    total++;
    if (bus.Out !== 16'h1234) begin bad++; $display("FAIL b2b_out: got %h want 1234", bus.Out); end
    $display("back_to_back: second ov_cycle=%0d Out=%h", ovc, bus.Out);
  endtask

  task automatic test_resync();
    int ovc, ovn, erc, ern;
    int early;
    logic [15:0] of;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, i == 0);
      if (bus.Err || bus.OutValid) early++;
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL resync_partial: got %0d pulses want 0", early); end
    send_frame(16'hBEEF, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (erc !== 1 || ern !== 1) begin bad++; $display("FAIL resync_err: cycle=%0d count=%0d want 1/1", erc, ern); end
    total++;
    if (of !== 16'h1234) begin bad++; $display("FAIL resync_hold: got %h want 1234", of); end
    total++;
    if (ovc !== 16 || ovn !== 1) begin bad++; $display("FAIL resync_ov: cycle=%0d count=%0d want 16/1", ovc, ovn); end
    total++;
    if (bus.Out !== 16'hBEEF) begin bad++; $display("FAIL resync_out: got %h want beef", bus.Out); end
    $display("resync: err_cycle=%0d ov_cycle=%0d Out=%h", erc, ovc, bus.Out);
  endtask

  task automatic test_boundary();
    int ovc, ovn, erc, ern;
    int stray;
    logic [15:0] of;
    step(1'b1, 1'b1, 1'b0);
    total++;
    if (bus.Err !== 1'b1 || bus.OutValid !== 1'b0) begin bad++; $display("FAIL boundary_err: Err=%b OutValid=%b want 1/0", bus.Err, bus.OutValid); end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus.Err || bus.OutValid) stray++;
    end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL boundary_idle: got %0d pulses want 0", stray); end
    total++;
    if (bus.Out !== 16'hBEEF) begin bad++; $display("FAIL boundary_hold: got %h want beef", bus.Out); end
    send_frame(16'h0F1E, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 16 || ovn !== 1 || ern !== 0) begin bad++; $display("FAIL boundary_restart: ov=%0d/%0d err=%0d want 16/1/0", ovc, ovn, ern); end
    total++;
    if (bus.Out !== 16'h0F1E) begin bad++; $display("FAIL boundary_out: got %h want 0f1e", bus.Out); end
    $display("boundary: ov_cycle=%0d Out=%h", ovc, bus.Out);
  endtask

  task automatic test_reset_mid();
    int ovc, ovn, erc, ern;
    logic [15:0] of;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++;
    if (bus.Out !== 16'h0000) begin bad++; $display("FAIL midreset_out: got %h want 0000", bus.Out); end
    total++;
    if (bus.OutValid !== 1'b0 || bus.Err !== 1'b0) begin bad++; $display("FAIL midreset_flags: OutValid=%b Err=%b want 0/0", bus.OutValid, bus.Err); end
    @(negedge clk);
    reset = 1'b0;
    send_frame(16'h8421, -1, 0, ovc, ovn, erc, ern, of);
    total++;
    if (ovc !== 16 || ern !== 0) begin bad++; $display("FAIL midreset_restart: ov=%0d err=%0d want 16/0", ovc, ern); end
    total++;
    if (bus.Out !== 16'h8421) begin bad++; $display("FAIL midreset_out2: got %h want 8421", bus.Out); end
    $display("reset_mid: ov_cycle=%0d Out=%h", ovc, bus.Out);
  endtask

  initial begin
    bus.In = 1'b0;
    bus.InValid = 1'b0;
    bus.Sync = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_gaps();
    test_back_to_back();
    test_resync();
    test_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
